// File: rtl/tsm_pkg.sv
// Shared definitions for the three-share masked AND chain: share/randomness
// counts, FSM state encoding and the latency helper.
`timescale 1ns/1ps
package tsm_pkg;

  localparam int NSH          = 3;
  localparam int RAND_PER_MUL = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    CMP  = 3'd2,
    RFR  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Edges from the accepting edge to out_valid high.
  function automatic int lat(input int n_in, input bit refresh);
    return 2 * (n_in - 1) + (refresh ? 1 : 0);
  endfunction

endpackage

// File: rtl/dom_and_2ndorder_stage.sv
// Second-order DOM AND gadget: nine share products with pairwise random
// injection, all nine terms registered, exposed as three row-XOR outputs.
`timescale 1ns/1ps
module dom_and_2ndorder_stage
  import tsm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NSH-1:0]          a,
  input  logic [NSH-1:0]          b,
  input  logic [RAND_PER_MUL-1:0] r,
  output logic [NSH-1:0]          z
);

  logic r01, r02, r12;
  logic [NSH-1:0][NSH-1:0] term_d;
  logic [NSH-1:0][NSH-1:0] term_q;

  assign r01 = r[0];
  assign r02 = r[1];
  assign r12 = r[2];

  // Each random bit enters exactly one pair of mirrored cross terms, so it cancels in the total.
  always_comb begin
    term_d[0] = {(a[0] & b[2]) ^ r02, (a[0] & b[1]) ^ r01, a[0] & b[0]};
    term_d[1] = {(a[1] & b[2]) ^ r12, a[1] & b[1], (a[1] & b[0]) ^ r01};
    term_d[2] = {a[2] & b[2], (a[2] & b[1]) ^ r12, (a[2] & b[0]) ^ r02};
  end

  // Term register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_q <= '0;
    end else if (en) begin
      term_q <= term_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NSH; i++) begin
      z[i] = ^term_q[i];
    end
  end

endmodule

// File: rtl/masked_and_chain_2ndorder_seq.sv
// Three-share masked N_IN-input AND, one registered DOM gadget reused over
// N_IN-1 multiplications. Define TSM_OUT_REFRESH_EN to add an output refresh.
`timescale 1ns/1ps
module masked_and_chain_2ndorder_seq
  import tsm_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         input_share1,
  input  logic [N_IN-1:0]         input_share2,
  input  logic [N_IN-1:0]         input_share3,
  input  logic [RAND_PER_MUL-1:0] rand_bit,
  output logic                    rand_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    output_share1,
  output logic                    output_share2,
  output logic                    output_share3
);

  localparam int KW = $clog2(N_IN + 1);

  state_t          state, state_nxt;
  logic [N_IN-1:0] op_s1, op_s2, op_s3;
  logic [NSH-1:0]  acc;
  logic [NSH-1:0]  xk;
  logic [NSH-1:0]  row;
  logic [KW-1:0]   k;
  logic            last_mul;
  logic            mul_en;

  assign last_mul = (k == KW'(N_IN));
  assign mul_en   = (state == MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = MUL;
      MUL:  state_nxt = CMP;
      CMP: begin
        if (last_mul) begin
`ifdef TSM_OUT_REFRESH_EN
          state_nxt = RFR;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = MUL;
        end
      end
`ifdef TSM_OUT_REFRESH_EN
      RFR:  state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    rand_en   = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready  = 1'b1;
      MUL:  rand_en   = 1'b1;
`ifdef TSM_OUT_REFRESH_EN
      RFR:  rand_en   = 1'b1;
`endif
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand for the current multiply: input k (1-based) from each share.
  always_comb begin
    xk = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (k == KW'(i + 1)) xk = {op_s3[i], op_s2[i], op_s1[i]};
    end
  end

  dom_and_2ndorder_stage u_gadget (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mul_en),
    .a     (acc),
    .b     (xk),
    .r     (rand_bit),
    .z     (row)
  );

  // Accumulator / operand stage: acc only ever loads from registered rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_s1 <= '0;
      op_s2 <= '0;
      op_s3 <= '0;
      acc   <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_s1 <= input_share1;
            op_s2 <= input_share2;
            op_s3 <= input_share3;
            acc   <= {input_share3[0], input_share2[0], input_share1[0]};
            k     <= KW'(2);
          end
        end
        CMP: begin
          acc <= row;
          if (!last_mul) k <= k + 1'b1;
        end
`ifdef TSM_OUT_REFRESH_EN
        RFR: begin
          acc <= acc ^ {rand_bit[1] ^ rand_bit[2],
                        rand_bit[0] ^ rand_bit[2],
                        rand_bit[0] ^ rand_bit[1]};
        end
`endif
        default: ;
      endcase
    end
  end

  assign output_share1 = acc[0];
  assign output_share2 = acc[1];
  assign output_share3 = acc[2];

endmodule

// File: tb/tb_masked_and_chain_2ndorder_seq.sv
// Directed bench for masked_and_chain_2ndorder_seq (N_IN = 4, 2, 16); honours
// TSM_OUT_REFRESH_EN for the expected latency and refresh masks.
`timescale 1ns/1ps
module tb_masked_and_chain_2ndorder_seq;
  import tsm_pkg::*;

`ifdef TSM_OUT_REFRESH_EN
  localparam bit REF = 1'b1;
`else
  localparam bit REF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rand_bit;

  logic       in_valid, in_ready, rand_en, out_valid, out_ready;
  logic [3:0] sh1, sh2, sh3;
  logic       o1, o2, o3;

  logic       v2, rdy2, ren2, ov2;
  logic [1:0] a2_1, a2_2, a2_3;
  logic       p2_1, p2_2, p2_3;

  logic        v16, rdy16, ren16, ov16;
  logic [15:0] a16_1, a16_2, a16_3;
  logic        p16_1, p16_2, p16_3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  masked_and_chain_2ndorder_seq #(.N_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .input_share1(sh1), .input_share2(sh2), .input_share3(sh3),
    .rand_bit(rand_bit), .rand_en(rand_en), .out_valid(out_valid),
    .out_ready(out_ready), .output_share1(o1), .output_share2(o2),
    .output_share3(o3)
  );

  masked_and_chain_2ndorder_seq #(.N_IN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
    .input_share1(a2_1), .input_share2(a2_2), .input_share3(a2_3),
    .rand_bit(rand_bit), .rand_en(ren2), .out_valid(ov2),
    .out_ready(1'b1), .output_share1(p2_1), .output_share2(p2_2),
    .output_share3(p2_3)
  );

  masked_and_chain_2ndorder_seq #(.N_IN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .input_share1(a16_1), .input_share2(a16_2), .input_share3(a16_3),
    .rand_bit(rand_bit), .rand_en(ren16), .out_valid(ov16),
    .out_ready(1'b1), .output_share1(p16_1), .output_share2(p16_2),
    .output_share3(p16_3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One N_IN=4 transaction; acc model: acc_i <- acc_i & (x_k1^x_k2^x_k3) ^ mask_i.
  task automatic txn4(input logic [3:0] x, input int stall);
    logic [3:0] s1, s2, s3, t1, t2, t3;
    logic [2:0] m_acc, mask, r;
    logic       xs;
    int         edges, nrand;
    bit         seen;
    s1 = 4'($urandom);
    s2 = 4'($urandom);
    s3 = x ^ s1 ^ s2;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    sh1 = s1; sh2 = s2; sh3 = s3;
    m_acc = {s3[0], s2[0], s1[0]};
    @(posedge clk); #1;
    in_valid = 1'b0;
    sh1 = 4'($urandom); sh2 = 4'($urandom); sh3 = 4'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    edges = 0; nrand = 0; seen = 0;
    while (!seen && edges < 200) begin
      @(negedge clk);
      r = 3'($urandom);
      rand_bit = r;
      if (rand_en) begin
        mask = {r[1] ^ r[2], r[0] ^ r[2], r[0] ^ r[1]};
        if (nrand < 3) begin
          t1 = s1 >> (nrand + 1);
          t2 = s2 >> (nrand + 1);
          t3 = s3 >> (nrand + 1);
          xs = t1[0] ^ t2[0] ^ t3[0];
          m_acc = (m_acc & {3{xs}}) ^ mask;
        end else begin
          m_acc = m_acc ^ mask;
        end
        nrand++;
      end
      @(posedge clk); #1;
      edges++;
      if (out_valid) seen = 1;
    end
    check("latency", 32'(edges), 32'(lat(4, REF)));
    check("rand_en_cycles", 32'(nrand), 32'(3 + int'(REF)));
    check("shares", 32'({o3, o2, o1}), 32'(m_acc));
    check("unmasked", 32'(o1 ^ o2 ^ o3), 32'(&x));
    repeat (stall) begin
      @(negedge clk);
      rand_bit = 3'($urandom);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_shares", 32'({o3, o2, o1}), 32'(m_acc));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_rand_en", 32'(rand_en), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("xfer_valid_low", 32'(out_valid), 32'd0);
    check("xfer_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int e, l2, l16;
    rst_n = 1'b0;
    rand_bit = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    sh1 = '0; sh2 = '0; sh3 = '0;
    v2 = 1'b0; a2_1 = '0; a2_2 = '0; a2_3 = '0;
    v16 = 1'b0; a16_1 = '0; a16_2 = '0; a16_3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rand_en", 32'(rand_en), 32'd0);
    check("rst_shares", 32'({o3, o2, o1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    txn4(4'b1111, 0);
    txn4(4'b1011, 0);
    txn4(4'b0000, 0);
    txn4(4'b1111, 5);

    // Reset asserted during the second MUL.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0;
    sh1 = 4'b0110; sh2 = 4'b1010; sh3 = 4'b0011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_rand_en", 32'(rand_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_rand_en", 32'(rand_en), 32'd0);
    check("midrst_shares", 32'({o3, o2, o1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn4(4'b1111, 0);

    for (int i = 0; i < 1000; i++) begin
      txn4(4'($urandom), 0);
    end

    // Boundary widths, all-ones input.
    @(negedge clk);
    a2_1 = 2'($urandom); a2_2 = 2'($urandom); a2_3 = 2'b11 ^ a2_1 ^ a2_2;
    a16_1 = 16'($urandom); a16_2 = 16'($urandom); a16_3 = 16'hFFFF ^ a16_1 ^ a16_2;
    v2 = 1'b1; v16 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0; v16 = 1'b0;
    e = 0; l2 = -1; l16 = -1;
    while ((l2 < 0 || l16 < 0) && e < 100) begin
      @(negedge clk);
      rand_bit = 3'($urandom);
      @(posedge clk); #1;
      e++;
      if (l2 < 0 && ov2) begin
        l2 = e;
        check("n2_unmasked", 32'(p2_1 ^ p2_2 ^ p2_3), 32'd1);
      end
      if (l16 < 0 && ov16) begin
        l16 = e;
        check("n16_unmasked", 32'(p16_1 ^ p16_2 ^ p16_3), 32'd1);
      end
    end
    check("n2_latency", 32'(l2), 32'(lat(2, REF)));
    check("n16_latency", 32'(l16), 32'(lat(16, REF)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
